// File: rtl/config_fsm_burst_if.sv
// Config-port bus for config_fsm_burst: word input handshake plus frame/row steering outputs.
// CheckError is present only when CONFIG_FRAME_CHECK_EN is defined.
interface config_fsm_burst_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int RowSelectWidth  = 5
);
  logic [31:0]                 write_data;
  logic                        write_strobe;
  logic [FrameBitsPerRow-1:0]  frame_address_register;
  logic                        long_frame_strobe;
  logic [RowSelectWidth-1:0]   row_select;
  logic                        synced;
  logic [15:0]                 frames_written;
`ifdef CONFIG_FRAME_CHECK_EN
  logic                        check_error;

  modport master (
    output write_data, write_strobe,
    input  frame_address_register, long_frame_strobe, row_select, synced,
           frames_written, check_error
  );

  modport slave (
    input  write_data, write_strobe,
    output frame_address_register, long_frame_strobe, row_select, synced,
           frames_written, check_error
  );
`else
  modport master (
    output write_data, write_strobe,
    input  frame_address_register, long_frame_strobe, row_select, synced,
           frames_written
  );

  modport slave (
    input  write_data, write_strobe,
    output frame_address_register, long_frame_strobe, row_select, synced,
           frames_written
  );
`endif
endinterface

// File: rtl/config_fsm_burst.sv
// Fabric configuration FSM with burst frames: sync detect, header decode, row steering, column advance.
// Optional per-frame checksum stage enabled by defining CONFIG_FRAME_CHECK_EN.
//
// state  | meaning
// UNSYNC | waiting for the sync word, all other words ignored
// HEADER | next word is a frame header (or a desync request)
// DATA   | receiving frame rows, NumberOfRows down to 1
// CHECK  | next word is the frame checksum (CONFIG_FRAME_CHECK_EN only)
module config_fsm_burst #(
  parameter int          NumberOfRows    = 14,
  parameter int          RowSelectWidth  = 5,
  parameter int          FrameBitsPerRow = 32,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
  parameter int          DesyncFlag      = 20,
  parameter int          BurstLSB        = 24
) (
  input logic             clk,
  input logic             reset,
  config_fsm_burst_if.slave bus
);

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_CHECK  = 2'd3;

  localparam logic [RowSelectWidth-1:0] ROWS_INIT = RowSelectWidth'(NumberOfRows);
  localparam logic [RowSelectWidth-1:0] ROW_LAST  = RowSelectWidth'(1);
  localparam logic [RowSelectWidth-1:0] ROW_NONE  = '1;

  logic [1:0]                 state;
  logic [RowSelectWidth-1:0]  row_cnt;
  logic [7:0]                 burst_remain;
  logic [FrameBitsPerRow-1:0] frame_addr;
  logic [FrameBitsPerRow-1:0] frame_addr_rot;
  logic                       frame_strobe;
  logic                       old_frame_strobe;
  logic                       long_frame_strobe;
  logic [15:0]                frames_written;
  logic                       accept_data;
  logic                       last_row;
  logic                       commit;

  assign accept_data = bus.write_strobe && (state == ST_DATA);
  assign last_row    = accept_data && (row_cnt == ROW_LAST);

  // one-hot column advance, MSB wraps back to bit 0
  assign frame_addr_rot = (frame_addr << 1) | (frame_addr >> (FrameBitsPerRow - 1));

`ifdef CONFIG_FRAME_CHECK_EN
  logic [31:0] frame_sum;
  logic        check_error;

  assign commit = bus.write_strobe && (state == ST_CHECK) && (bus.write_data == frame_sum);
`else
  assign commit = last_row;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_UNSYNC;
      row_cnt           <= '0;
      burst_remain      <= '0;
      frame_addr        <= '0;
      frame_strobe      <= 1'b0;
      old_frame_strobe  <= 1'b0;
      long_frame_strobe <= 1'b0;
      frames_written    <= '0;
`ifdef CONFIG_FRAME_CHECK_EN
      frame_sum         <= '0;
      check_error       <= 1'b0;
`endif
    end else begin
      frame_strobe      <= 1'b0;
      old_frame_strobe  <= frame_strobe;
      long_frame_strobe <= frame_strobe | old_frame_strobe;

      if (bus.write_strobe) begin
        case (state)
          ST_UNSYNC: begin
            if (bus.write_data == SyncWord) state <= ST_HEADER;
          end
          ST_HEADER: begin
            if (bus.write_data[DesyncFlag]) begin
              state <= ST_UNSYNC;
            end else begin
              frame_addr   <= bus.write_data[FrameBitsPerRow-1:0];
              burst_remain <= bus.write_data[BurstLSB +: 8];
              row_cnt      <= ROWS_INIT;
              state        <= ST_DATA;
`ifdef CONFIG_FRAME_CHECK_EN
              frame_sum    <= '0;
`endif
            end
          end
          ST_DATA: begin
            row_cnt <= row_cnt - ROW_LAST;
`ifdef CONFIG_FRAME_CHECK_EN
            frame_sum <= frame_sum + bus.write_data;
            if (last_row) state <= ST_CHECK;
`endif
          end
          default: begin
`ifdef CONFIG_FRAME_CHECK_EN
            // a bad checksum drops the rest of the burst; resync required
            if (!commit) begin
              check_error <= 1'b1;
              state       <= ST_UNSYNC;
            end
`else
            state <= ST_UNSYNC;
`endif
          end
        endcase
      end

      // placed after the case so the frame boundary wins over the per-word updates
      if (commit) begin
        frame_strobe <= 1'b1;
        if (frames_written != 16'hFFFF) frames_written <= frames_written + 16'd1;
        if (burst_remain == 8'd0) begin
          state <= ST_HEADER;
        end else begin
          burst_remain <= burst_remain - 8'd1;
          frame_addr   <= frame_addr_rot;
          row_cnt      <= ROWS_INIT;
          state        <= ST_DATA;
`ifdef CONFIG_FRAME_CHECK_EN
          frame_sum    <= '0;
`endif
        end
      end
    end
  end

  assign bus.row_select             = accept_data ? row_cnt : ROW_NONE;
  assign bus.frame_address_register = frame_addr;
  assign bus.long_frame_strobe      = long_frame_strobe;
  assign bus.synced                 = (state != ST_UNSYNC);
  assign bus.frames_written         = frames_written;
`ifdef CONFIG_FRAME_CHECK_EN
  assign bus.check_error            = check_error;
`endif

endmodule
